// File: rtl/i2c_codec_responder.sv
// Write-only I2C codec control responder with an R0..R9 9-bit register file and 1-cycle registered readback.
// Macro I2C_CODEC_RESPONDER_RESET_REG_EN makes a write to 0x0F restore all defaults; the I2C side has no backpressure.
module i2c_codec_responder #(
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda_oen,
   output logic       o_reg_we,
   output logic [6:0] o_reg_addr,
   output logic [8:0] o_reg_data,
   output logic       o_wr_err,
   output logic       o_busy,
   input  logic [3:0] i_rd_addr,
   output logic [8:0] o_rd_data
);
   typedef enum logic [2:0] {IDLE, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, IGNORE} state_t;

   localparam int         NREG   = 10;
   localparam logic [6:0] NREG_A = 7'd10;

   function automatic logic [8:0] reg_default(input int idx);
      case (idx)
         0, 1:    reg_default = 9'h097;
         2, 3:    reg_default = 9'h079;
         4, 7:    reg_default = 9'h00A;
         5:       reg_default = 9'h008;
         6:       reg_default = 9'h09F;
         default: reg_default = 9'h000;
      endcase
   endfunction

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic       scl_prev_q, sda_prev_q;
   logic       scl_s, sda_s;
   logic       start_det, stop_det, scl_rise, scl_fall;

   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] reg_byte_q, reg_byte_d;
   logic [7:0] data_byte_q, data_byte_d;
   logic       commit;

   logic [6:0] commit_addr;
   logic [8:0] commit_data;
   logic       reg_we_q, reg_we_d;
   logic       wr_err_q, wr_err_d;
   logic [6:0] reg_addr_q, reg_addr_d;
   logic [8:0] reg_data_q, reg_data_d;
   logic [8:0] rd_data_q, rd_data_d;
   logic [8:0] regs_q [NREG];
   logic [8:0] regs_d [NREG];

   always_comb begin
      scl_sync_d[0] = i_scl;
      sda_sync_d[0] = i_sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         scl_sync_d[i] = scl_sync_q[i-1];
         sda_sync_d[i] = sda_sync_q[i-1];
      end
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;

   // State register, synchronizers and receive datapath
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scl_sync_q  <= '1;
         sda_sync_q  <= '1;
         scl_prev_q  <= 1'b1;
         sda_prev_q  <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         reg_byte_q  <= '0;
         data_byte_q <= '0;
      end else begin
         scl_sync_q  <= scl_sync_d;
         sda_sync_q  <= sda_sync_d;
         scl_prev_q  <= scl_s;
         sda_prev_q  <= sda_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         reg_byte_q  <= reg_byte_d;
         data_byte_q <= data_byte_d;
      end
   end

   // Next-state: bytes close on the SCL fall after their 8th rise, ACK bits on the following fall
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      reg_byte_d  = reg_byte_q;
      data_byte_d = data_byte_q;
      commit      = 1'b0;
      if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
      end else if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = '0;
         shift_d   = '0;
      end else begin
         case (state_q)
            ADDR, REG, DATA: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                  bit_cnt_d = '0;
                  if (state_q == ADDR) begin
                     state_d = (shift_q == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                  end else if (state_q == REG) begin
                     state_d    = ACK_R;
                     reg_byte_d = shift_q;
                  end else begin
                     state_d     = ACK_D;
                     data_byte_d = shift_q;
                  end
               end
            end
            ACK_A: if (scl_fall) state_d = REG;
            ACK_R: if (scl_fall) state_d = DATA;
            ACK_D: begin
               if (scl_fall) begin
                  state_d = IGNORE;
                  commit  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Decoded straight from the state register so an async reset releases SDA at once
   always_comb begin
      o_sda_oen = (state_q == ACK_A) || (state_q == ACK_R) || (state_q == ACK_D);
      o_busy    = (state_q != IDLE);
   end

   assign commit_addr = reg_byte_q[7:1];
   assign commit_data = {reg_byte_q[0], data_byte_q};

   always_comb begin
      regs_d     = regs_q;
      reg_we_d   = commit;
      wr_err_d   = 1'b0;
      reg_addr_d = reg_addr_q;
      reg_data_d = reg_data_q;
      if (commit) begin
         reg_addr_d = commit_addr;
         reg_data_d = commit_data;
         if (commit_addr < NREG_A) begin
            for (int i = 0; i < NREG; i++) begin
               if (commit_addr == 7'(i)) regs_d[i] = commit_data;
            end
         end
`ifdef I2C_CODEC_RESPONDER_RESET_REG_EN
         else if (commit_addr == 7'h0F) begin
            for (int i = 0; i < NREG; i++) regs_d[i] = reg_default(i);
         end
`endif
         else begin
            wr_err_d = 1'b1;
         end
      end
      // Reads see regs_q, so a same-cycle commit to the same register returns the old value
      rd_data_d = '0;
      for (int i = 0; i < NREG; i++) begin
         if (i_rd_addr == 4'(i)) rd_data_d = regs_q[i];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         reg_we_q   <= 1'b0;
         wr_err_q   <= 1'b0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         rd_data_q  <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= reg_default(i);
      end else begin
         reg_we_q   <= reg_we_d;
         wr_err_q   <= wr_err_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         rd_data_q  <= rd_data_d;
         regs_q     <= regs_d;
      end
   end

   assign o_reg_we   = reg_we_q;
   assign o_wr_err   = wr_err_q;
   assign o_reg_addr = reg_addr_q;
   assign o_reg_data = reg_data_q;
   assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C master against a transaction-level register model.
// Directed scenarios plus randomized writes; honours I2C_CODEC_RESPONDER_RESET_REG_EN when defined.
module tb_i2c_codec_responder;
   localparam int H = 10;
   localparam int Q = 5;
`ifdef I2C_CODEC_RESPONDER_RESET_REG_EN
   localparam bit RESET_REG_EN = 1'b1;
`else
   localparam bit RESET_REG_EN = 1'b0;
`endif

   logic       clk, rst_n, scl, sda_m, sda_line;
   logic       o_sda_oen, o_reg_we, o_wr_err, o_busy;
   logic [6:0] o_reg_addr;
   logic [8:0] o_reg_data, o_rd_data;
   logic [3:0] rd_addr;

   int n_checks = 0;
   int n_fail   = 0;
   int we_cnt   = 0;
   int err_cnt  = 0;
   logic [8:0] rd_at_we;

   logic [8:0] mregs [0:9];
   logic [6:0] m_last_addr;
   logic [8:0] m_last_data;
   logic [7:0] tx [0:7];
   logic [7:0] ack_mask, exp_ack;
   logic       exp_commit, exp_err;

   assign sda_line = sda_m & ~o_sda_oen;

   i2c_codec_responder dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_scl(scl), .i_sda(sda_line),
      .o_sda_oen(o_sda_oen), .o_reg_we(o_reg_we), .o_reg_addr(o_reg_addr),
      .o_reg_data(o_reg_data), .o_wr_err(o_wr_err), .o_busy(o_busy),
      .i_rd_addr(rd_addr), .o_rd_data(o_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_reg_we) begin
         we_cnt++;
         rd_at_we = o_rd_data;
      end
      if (o_wr_err) err_cnt++;
   end

   task automatic model_defaults();
      mregs[0] = 9'h097; mregs[1] = 9'h097; mregs[2] = 9'h079; mregs[3] = 9'h079;
      mregs[4] = 9'h00A; mregs[5] = 9'h008; mregs[6] = 9'h09F; mregs[7] = 9'h00A;
      mregs[8] = 9'h000; mregs[9] = 9'h000;
   endtask

   // Transaction-level expectation for one START..bytes sequence of n bytes
   task automatic model_xfer(input int n);
      logic [6:0] a;
      logic [8:0] d;
      exp_ack = '0; exp_commit = 1'b0; exp_err = 1'b0;
      if (n >= 1 && tx[0] == 8'h34) begin
         for (int i = 0; i < n && i < 3; i++) exp_ack[i] = 1'b1;
         if (n >= 3) begin
            exp_commit = 1'b1;
            a = tx[1][7:1];
            d = {tx[1][0], tx[2]};
            m_last_addr = a;
            m_last_data = d;
            if (a < 7'd10) mregs[a] = d;
            else if (RESET_REG_EN && a == 7'h0F) model_defaults();
            else exp_err = 1'b1;
         end
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_clk(Q);
      scl = 1'b1;   wait_clk(H);
      sda_m = 1'b0; wait_clk(H);
      scl = 1'b0;   wait_clk(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_clk(Q);
      scl = 1'b1;   wait_clk(H);
      sda_m = 1'b1; wait_clk(H);
   endtask

   task automatic i2c_bit(input logic b);
      sda_m = b;  wait_clk(Q);
      scl = 1'b1; wait_clk(H);
      scl = 1'b0; wait_clk(Q);
   endtask

   task automatic i2c_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
      sda_m = 1'b1; wait_clk(Q);
      scl = 1'b1;   wait_clk(H/2);
      #1 ack = ~sda_line;
      wait_clk(H/2);
      scl = 1'b0;   wait_clk(Q);
   endtask

   task automatic run_xfer(input int n, input bit do_stop);
      logic a;
      ack_mask = '0;
      i2c_start();
      for (int i = 0; i < n; i++) begin
         i2c_byte(tx[i], a);
         ack_mask[i] = a;
      end
      if (do_stop) i2c_stop();
   endtask

   task automatic read_reg(input int a, output logic [8:0] d);
      @(negedge clk);
      rd_addr = 4'(a);
      @(posedge clk);
      #1 d = o_rd_data;
   endtask

   task automatic test_reset();
      logic [8:0] d;
      rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; rd_addr = 4'd0;
      model_defaults();
      m_last_addr = '0; m_last_data = '0;
      wait_clk(4);
      #1;
      n_checks++;
      if ({o_sda_oen, o_reg_we, o_wr_err, o_busy, o_reg_addr, o_reg_data, o_rd_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got oen=%b we=%b err=%b busy=%b addr=%h data=%h rd=%h expected all zero",
                  o_sda_oen, o_reg_we, o_wr_err, o_busy, o_reg_addr, o_reg_data, o_rd_data);
      end
      @(negedge clk) rst_n = 1'b1;
      wait_clk(4);
      for (int i = 0; i < 16; i++) begin
         read_reg(i, d);
         n_checks++;
         if (d !== ((i < 10) ? mregs[i] : 9'h000)) begin
            n_fail++;
            $display("FAIL reset_default[%0d]: got %h expected %h", i, d, (i < 10) ? mregs[i] : 9'h000);
         end
      end
   endtask

   task automatic test_write_basic();
      int we0, err0;
      logic [8:0] d, old7;
      old7 = mregs[7];
      we0 = we_cnt; err0 = err_cnt;
      @(negedge clk) rd_addr = 4'd7;
      tx[0] = 8'h34; tx[1] = 8'h0E; tx[2] = 8'h42;
      model_xfer(3);
      run_xfer(3, 1'b0);
      #1;
      n_checks++;
      if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_high: got %b expected 1", o_busy); end
      i2c_stop();
      #1;
      n_checks++;
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_low: got %b expected 0", o_busy); end
      n_checks++;
      if (ack_mask !== exp_ack) begin n_fail++; $display("FAIL basic_acks: got %b expected %b", ack_mask, exp_ack); end
      n_checks++;
      if (we_cnt - we0 !== 1 || err_cnt != err0) begin
         n_fail++; $display("FAIL basic_we: got we=%0d err=%0d expected we=1 err=0", we_cnt - we0, err_cnt - err0);
      end
      n_checks++;
      if (o_reg_addr !== 7'd7 || o_reg_data !== 9'h042) begin
         n_fail++; $display("FAIL basic_commit: got addr=%h data=%h expected addr=07 data=042", o_reg_addr, o_reg_data);
      end
      n_checks++;
      if (rd_at_we !== old7) begin n_fail++; $display("FAIL same_cycle_read: got %h expected %h", rd_at_we, old7); end
      read_reg(7, d);
      n_checks++;
      if (d !== 9'h042) begin n_fail++; $display("FAIL basic_readback: got %h expected 042", d); end
   endtask

   task automatic test_wrong_addr();
      int we0;
      logic [8:0] d;
      we0 = we_cnt;
      for (int k = 0; k < 2; k++) begin
         tx[0] = (k == 0) ? 8'h36 : 8'h35; tx[1] = 8'h10; tx[2] = 8'h55;
         model_xfer(3);
         run_xfer(3, 1'b1);
         n_checks++;
         if (ack_mask !== exp_ack) begin n_fail++; $display("FAIL wrong_addr_acks[%0d]: got %b expected %b", k, ack_mask, exp_ack); end
      end
      n_checks++;
      if (we_cnt != we0) begin n_fail++; $display("FAIL wrong_addr_we: got %0d expected 0", we_cnt - we0); end
      for (int i = 0; i < 10; i++) begin
         read_reg(i, d);
         n_checks++;
         if (d !== mregs[i]) begin n_fail++; $display("FAIL wrong_addr_reg[%0d]: got %h expected %h", i, d, mregs[i]); end
      end
   endtask

   task automatic test_extra_byte();
      int we0;
      logic [8:0] d;
      we0 = we_cnt;
      tx[0] = 8'h34; tx[1] = 8'h09; tx[2] = 8'h23; tx[3] = 8'hAA;
      model_xfer(4);
      run_xfer(4, 1'b1);
      n_checks++;
      if (ack_mask !== exp_ack) begin n_fail++; $display("FAIL extra_acks: got %b expected %b", ack_mask, exp_ack); end
      n_checks++;
      if (we_cnt - we0 != 1) begin n_fail++; $display("FAIL extra_we: got %0d expected 1", we_cnt - we0); end
      read_reg(4, d);
      n_checks++;
      if (d !== 9'h123) begin n_fail++; $display("FAIL extra_r4: got %h expected 123", d); end
   endtask

   task automatic test_stop_midway();
      int we0;
      logic [8:0] d;
      we0 = we_cnt;
      tx[0] = 8'h34; tx[1] = 8'h0C;
      model_xfer(2);
      run_xfer(2, 1'b1);
      #1;
      n_checks++;
      if (ack_mask !== exp_ack || o_busy !== 1'b0) begin
         n_fail++; $display("FAIL stop_acks_busy: got ack=%b busy=%b expected ack=%b busy=0", ack_mask, o_busy, exp_ack);
      end
      n_checks++;
      if (we_cnt != we0) begin n_fail++; $display("FAIL stop_we: got %0d expected 0", we_cnt - we0); end
      read_reg(6, d);
      n_checks++;
      if (d !== 9'h09F) begin n_fail++; $display("FAIL stop_r6: got %h expected 09f", d); end
   endtask

   task automatic test_reset_reg();
      int we0, err0;
      logic [8:0] d;
      we0 = we_cnt; err0 = err_cnt;
      tx[0] = 8'h34; tx[1] = 8'h1E; tx[2] = 8'h00;
      model_xfer(3);
      run_xfer(3, 1'b1);
      n_checks++;
      if (ack_mask !== exp_ack || we_cnt - we0 != 1 || (err_cnt - err0) != int'(exp_err)) begin
         n_fail++; $display("FAIL reg15: got ack=%b we=%0d err=%0d expected ack=%b we=1 err=%0d",
                            ack_mask, we_cnt - we0, err_cnt - err0, exp_ack, exp_err);
      end
      for (int i = 0; i < 10; i++) begin
         read_reg(i, d);
         n_checks++;
         if (d !== mregs[i]) begin n_fail++; $display("FAIL reg15_reg[%0d]: got %h expected %h", i, d, mregs[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int we0;
      logic [8:0] d;
      we0 = we_cnt;
      tx[0] = 8'h34; tx[1] = 8'h0A;
      model_xfer(2);
      run_xfer(2, 1'b0);
      tx[2] = 8'h55;
      model_xfer(3);
      run_xfer(3, 1'b0);
      tx[1] = 8'h02; tx[2] = 8'h11;
      model_xfer(3);
      run_xfer(3, 1'b1);
      n_checks++;
      if (we_cnt - we0 != 2) begin n_fail++; $display("FAIL b2b_we: got %0d expected 2", we_cnt - we0); end
      read_reg(5, d);
      n_checks++;
      if (d !== mregs[5]) begin n_fail++; $display("FAIL b2b_r5: got %h expected %h", d, mregs[5]); end
      read_reg(1, d);
      n_checks++;
      if (d !== mregs[1]) begin n_fail++; $display("FAIL b2b_r1: got %h expected %h", d, mregs[1]); end
   endtask

   task automatic test_random();
      int we0, err0, n;
      logic [6:0] a;
      logic [8:0] d;
      for (int it = 0; it < 25; it++) begin
         we0 = we_cnt; err0 = err_cnt;
         tx[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
         a = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(10, 15)) : 7'($urandom_range(0, 9));
         tx[1] = {a, 1'($urandom)};
         tx[2] = 8'($urandom);
         tx[3] = 8'($urandom);
         n = $urandom_range(1, 4);
         model_xfer(n);
         run_xfer(n, 1'b1);
         n_checks++;
         if (ack_mask !== exp_ack || (we_cnt - we0) != int'(exp_commit) || (err_cnt - err0) != int'(exp_err)) begin
            n_fail++; $display("FAIL rand_xfer[%0d]: got ack=%b we=%0d err=%0d expected ack=%b we=%0d err=%0d",
                               it, ack_mask, we_cnt - we0, err_cnt - err0, exp_ack, exp_commit, exp_err);
         end
         n_checks++;
         if (o_reg_addr !== m_last_addr || o_reg_data !== m_last_data) begin
            n_fail++; $display("FAIL rand_last[%0d]: got %h/%h expected %h/%h", it, o_reg_addr, o_reg_data, m_last_addr, m_last_data);
         end
         read_reg($urandom_range(0, 15), d);
         n_checks++;
         if (d !== ((rd_addr < 4'd10) ? mregs[rd_addr] : 9'h000)) begin
            n_fail++; $display("FAIL rand_read[%0d]: addr %0d got %h expected %h", it, rd_addr, d,
                               (rd_addr < 4'd10) ? mregs[rd_addr] : 9'h000);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic a;
      logic [8:0] d;
      tx[0] = 8'h34; tx[1] = 8'h01; tx[2] = 8'hFF;
      model_xfer(3);
      run_xfer(3, 1'b1);
      i2c_start();
      i2c_byte(8'h34, a);
      for (int i = 7; i >= 0; i--) i2c_bit(1'(8'h0E >> i));
      sda_m = 1'b1;
      wait_clk(Q);
      #1;
      n_checks++;
      if (o_sda_oen !== 1'b1) begin n_fail++; $display("FAIL midrst_ack_r: got %b expected 1", o_sda_oen); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (o_sda_oen !== 1'b0 || o_busy !== 1'b0) begin
         n_fail++; $display("FAIL midrst_release: got oen=%b busy=%b expected 0/0", o_sda_oen, o_busy);
      end
      scl = 1'b1; sda_m = 1'b1;
      model_defaults();
      m_last_addr = '0; m_last_data = '0;
      wait_clk(3);
      @(negedge clk) rst_n = 1'b1;
      wait_clk(4);
      read_reg(0, d);
      n_checks++;
      if (d !== mregs[0] || o_reg_addr !== 7'd0) begin
         n_fail++; $display("FAIL midrst_r0: got %h addr %h expected %h addr 00", d, o_reg_addr, mregs[0]);
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_wrong_addr();
      test_extra_byte();
      test_stop_midway();
      test_reset_reg();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, is the 7-bit device address (write byte 0x34).
REQ-002 Parameter SYNC_STAGES, default 2, is the number of synchronizer flops on i_scl and i_sda.
REQ-003 Port i_clk, input, 1: the single clock; every flop in the block is clocked by it.
REQ-004 Port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port i_scl, input, 1: I2C clock line (asynchronous to i_clk).
REQ-006 Port i_sda, input, 1: resolved I2C data line value.
REQ-007 Port o_sda_oen, output, 1: 1 means pull SDA low (ACK); 0 means release.
REQ-008 Port o_reg_we, output, 1: one-cycle pulse on each committed register write.
REQ-009 Port o_reg_addr, output, 7: register address of the last commit, held until the next commit.
REQ-010 Port o_reg_data, output, 9: register data of the last commit, held until the next commit.
REQ-011 Port o_wr_err, output, 1: one-cycle pulse when a complete write targets an unsupported register.
REQ-012 Port o_busy, output, 1: high from START until STOP.
REQ-013 Port i_rd_addr, input, 4, and port o_rd_data, output, 9: register-file readback with 1-cycle registered latency.

Function
REQ-014 The block passes i_scl and i_sda through SYNC_STAGES flops; START, STOP, SCL-rise and SCL-fall are detected from the synchronized values.
REQ-015 SCL high and low times of at least SYNC_STAGES+2 i_clk cycles are a supported operating condition.
REQ-016 START is SDA falling while SCL is high; STOP is SDA rising while SCL is high.
REQ-017 Data bits are sampled MSB first on each SCL rise.
REQ-018 The FSM states are IDLE, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D and IGNORE.
REQ-019 A START from any state clears the bit counter and shift register and enters ADDR; a repeated START discards the partial transfer.
REQ-020 A STOP from any state enters IDLE, drops o_busy and discards any uncommitted transfer.
REQ-021 After 8 bits in ADDR, a byte equal to {DEV_ADDR,1'b0} moves the FSM to ACK_A; any other byte, including a read request, moves it to IGNORE with no ACK.
REQ-022 In any ACK state, o_sda_oen rises on the SCL fall ending bit 8 and drops on the next SCL fall.
REQ-023 The byte received in REG supplies reg address [7:1] and data bit 8 [0]; the byte received in DATA supplies data [7:0].
REQ-024 Commit occurs on the SCL fall ending the ACK_D bit, with o_reg_we asserted the following i_clk cycle; the FSM then enters IGNORE.
REQ-025 Bytes arriving after a commit are NACKed (o_sda_oen stays 0) until the next STOP or START.
REQ-026 The register file holds R0..R9, each 9 bits wide.
REQ-027 Register defaults are R0 0x097, R1 0x097, R2 0x079, R3 0x079, R4 0x00A, R5 0x008, R6 0x09F, R7 0x00A, R8 0x000 and R9 0x000.
REQ-028 A commit to an address of 0..9 updates that register.
REQ-029 A commit to an unsupported address (see REQ-034) is still ACKed and still pulses o_reg_we, but leaves the file unchanged and pulses o_wr_err in the same cycle.
REQ-030 o_rd_data returns 0 for i_rd_addr values above 9.
REQ-031 If a readback and a commit hit the same register in the same cycle, the read returns the old value.

Reset
REQ-032 While i_rst_n is low: FSM is IDLE, synchronizers are reset to 1, o_sda_oen, o_reg_we, o_wr_err and o_busy are 0, o_reg_addr and o_reg_data are 0, o_rd_data is 0, and registers take their REQ-027 defaults.
REQ-033 A reset asserted mid-transfer releases SDA immediately (asynchronously) and discards the transfer.

Configuration
REQ-034 Macro I2C_CODEC_RESPONDER_RESET_REG_EN controls register 0x0F handling:
- Defined: a commit to 0x0F with any data restores all REQ-027 defaults in one cycle, without o_wr_err.
- Undefined: 0x0F is unsupported and follows REQ-029.

Verification
REQ-035 Write 0x34,0x0E,0x42 -> 3 ACKs, o_reg_we pulse, o_reg_addr=7, o_reg_data=0x042, readback of 7 returns 0x042.
REQ-036 Write 0x36,... -> no ACK on any byte, no o_reg_we, register file unchanged.
REQ-037 Write 0x34,0x09,0x23 -> ACKs, R4=0x123; a fourth byte is NACKed with no second commit.
REQ-038 Write 0x34,0x0C, STOP -> no commit, R6 stays 0x09F, o_busy falls.
REQ-039 Write 0x34,0x1E,0x00 -> with the macro, all registers return to defaults; without it, o_wr_err pulses and the file is unchanged.
REQ-040 Assert i_rst_n low during the ACK_R bit -> o_sda_oen drops to 0 at once and registers return to defaults.
